// File: rtl/unidad_control.sv
// rtl/unidad_control.sv - CS3 hardwired control unit; define UC_STACK_EN to sequence CALL/RET
module unidad_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] op,
  input  logic [2:0] condicion,
  input  logic [3:0] regestado,
  output logic       wreg,
  output logic       wmem,
  output logic       rmem,
  output logic       wir,
  output logic       wmar,
  output logic       ipc,
  output logic       clpc,
  output logic       wpc,
  output logic       rpc,
  output logic       inm,
  output logic       rac,
  output logic       wac,
  output logic       s,
  output logic       r,
  output logic       ta,
  output logic       tb,
  output logic       wsreg,
  output logic       isp,
  output logic       dsp,
  output logic       rsp,
  output logic       prsp,
  output logic       enable_mux_carry,
  output logic       halt
);

  localparam logic [1:0] S_RST   = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EX    = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [4:0] OP_ST   = 5'b00000;
  localparam logic [4:0] OP_LD   = 5'b00001;
  localparam logic [4:0] OP_STS  = 5'b00010;
  localparam logic [4:0] OP_LDS  = 5'b00011;
  localparam logic [4:0] OP_CALL = 5'b00100;
  localparam logic [4:0] OP_RET  = 5'b00101;
  localparam logic [4:0] OP_BR   = 5'b00110;
  localparam logic [4:0] OP_JMP  = 5'b00111;
  localparam logic [4:0] OP_ADD  = 5'b01000;
  localparam logic [4:0] OP_SUB  = 5'b01010;
  localparam logic [4:0] OP_CP   = 5'b01011;
  localparam logic [4:0] OP_MOV  = 5'b01111;
  localparam logic [4:0] OP_STOP = 5'b10111;
  localparam logic [4:0] OP_SUBI = 5'b11010;
  localparam logic [4:0] OP_CPI  = 5'b11011;
  localparam logic [4:0] OP_SBCI = 5'b11100;
  localparam logic [4:0] OP_LDI  = 5'b11111;

  logic [1:0] state, state_nx;
  logic [1:0] step, step_nx;
  logic       br_taken;
  logic [1:0] last_step;
  logic       to_halt;

  // Branch condition from status {c,n,z,v}
  always_comb begin
    case (condicion)
      3'd0:    br_taken = regestado[1];
      3'd1:    br_taken = regestado[3];
      3'd2:    br_taken = regestado[0];
      3'd3:    br_taken = regestado[2] ^ regestado[0];
      default: br_taken = 1'b0;
    endcase
  end

  // Final EX step of the current opcode, and whether it ends in HALT
  always_comb begin
    last_step = 2'd0;
    to_halt   = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_SUBI, OP_SBCI,
      OP_LDI, OP_MOV, OP_JMP:            last_step = 2'd1;
      OP_LD, OP_LDS:                     last_step = 2'd2;
      OP_ST, OP_STS:                     last_step = 2'd3;
      OP_BR:                             last_step = br_taken ? 2'd1 : 2'd0;
`ifdef UC_STACK_EN
      OP_CALL:                           last_step = 2'd3;
      OP_RET:                            last_step = 2'd2;
`endif
      OP_STOP:                           to_halt = 1'b1;
      default:                           last_step = 2'd0;
    endcase
  end

  // Next state / step; >= keeps the counter from running past the end
  always_comb begin
    state_nx = state;
    step_nx  = 2'd0;
    case (state)
      S_RST:   state_nx = S_FETCH;
      S_FETCH: state_nx = S_EX;
      S_EX: begin
        if (step >= last_step) begin
          state_nx = to_halt ? S_HALT : S_FETCH;
        end else begin
          step_nx = step + 2'd1;
        end
      end
      default: state_nx = S_HALT;
    endcase
  end

  // State register, forced to RST asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RST;
      step  <= 2'd0;
    end else begin
      state <= state_nx;
      step  <= step_nx;
    end
  end

  // Strobe decode from state, step and opcode
  always_comb begin
    wreg = 1'b0; wmem = 1'b0; rmem = 1'b0; wir = 1'b0; wmar = 1'b0;
    ipc = 1'b0; clpc = 1'b0; wpc = 1'b0; rpc = 1'b0; inm = 1'b0;
    rac = 1'b0; wac = 1'b0; s = 1'b0; r = 1'b0; ta = 1'b0; tb = 1'b0;
    wsreg = 1'b0; isp = 1'b0; dsp = 1'b0; rsp = 1'b0; prsp = 1'b0;
    enable_mux_carry = 1'b0; halt = 1'b0;
    case (state)
      S_RST: begin
        clpc = 1'b1;
        prsp = 1'b1;
      end
      S_FETCH: begin
        wir = 1'b1;
        ipc = 1'b1;
      end
      S_HALT: halt = 1'b1;
      default: begin
        case (op)
          OP_ADD, OP_SUB, OP_SUBI, OP_SBCI: begin
            if (step == 2'd0) begin
              s     = (op == OP_ADD);
              r     = (op != OP_ADD);
              inm   = (op == OP_SUBI) || (op == OP_SBCI);
              enable_mux_carry = (op == OP_SBCI);
              wac   = 1'b1;
              wsreg = 1'b1;
            end else begin
              rac  = 1'b1;
              wreg = 1'b1;
            end
          end
          OP_CP, OP_CPI: begin
            r     = 1'b1;
            wsreg = 1'b1;
            wac   = 1'b1;
            inm   = (op == OP_CPI);
          end
          OP_LDI, OP_MOV: begin
            if (step == 2'd0) begin
              wac = 1'b1;
              inm = (op == OP_LDI);
            end else begin
              rac  = 1'b1;
              wreg = 1'b1;
            end
          end
          OP_LD, OP_LDS: begin
            case (step)
              2'd0: begin wac = 1'b1; inm = (op == OP_LDS); end
              2'd1: begin rac = 1'b1; wmar = 1'b1; end
              default: begin rmem = 1'b1; wreg = 1'b1; end
            endcase
          end
          OP_ST, OP_STS: begin
            case (step)
              2'd0: begin wac = 1'b1; inm = (op == OP_STS); end
              2'd1: begin rac = 1'b1; wmar = 1'b1; end
              2'd2: begin ta = 1'b1; wac = 1'b1; end
              default: begin rac = 1'b1; wmem = 1'b1; end
            endcase
          end
          OP_JMP, OP_BR: begin
            // Untaken branch simply ends after a silent E0
            if (op == OP_JMP || br_taken) begin
              if (step == 2'd0) begin
                inm = 1'b1;
                wac = 1'b1;
              end else begin
                rac = 1'b1;
                wpc = 1'b1;
              end
            end
          end
`ifdef UC_STACK_EN
          OP_CALL: begin
            case (step)
              2'd0: begin rsp = 1'b1; wmar = 1'b1; end
              2'd1: begin rpc = 1'b1; wmem = 1'b1; dsp = 1'b1; end
              2'd2: begin inm = 1'b1; wac = 1'b1; end
              default: begin rac = 1'b1; wpc = 1'b1; end
            endcase
          end
          OP_RET: begin
            case (step)
              2'd0: isp = 1'b1;
              2'd1: begin rsp = 1'b1; wmar = 1'b1; end
              default: begin rmem = 1'b1; wpc = 1'b1; end
            endcase
          end
`endif
          default: ;
        endcase
      end
    endcase
  end

endmodule
